// File: rtl/sumador_pkg.sv
// rtl/sumador_pkg.sv - mode encodings and wide add/subtract helper for sumador_param
package sumador_pkg;

  localparam logic [1:0] MODO_LOAD = 2'b00;
  localparam logic [1:0] MODO_ADD  = 2'b01;
  localparam logic [1:0] MODO_SUB  = 2'b10;
  localparam logic [1:0] MODO_ACC  = 2'b11;

  // Widest operand the helper supports; callers zero-extend into it.
  localparam int MAX_W = 64;

  // Bit W of the result is the carry (add) or borrow (sub) for W-bit operands.
  function automatic logic [MAX_W:0] addsub(input logic [MAX_W-1:0] x,
                                            input logic [MAX_W-1:0] y,
                                            input logic             c,
                                            input logic             sub);
    logic [MAX_W:0] xe, ye, ce;
    xe = {1'b0, x};
    ye = {1'b0, y};
    ce = {{MAX_W{1'b0}}, c};
    if (sub) addsub = xe - ye - ce;
    else     addsub = xe + ye + ce;
  endfunction

endpackage

// File: rtl/sumador_param_if.sv
// rtl/sumador_param_if.sv - operand/result bundle between stimulus and sumador_param
interface sumador_param_if #(parameter int W = 8);
  logic         enb;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [1:0]   modo;
  logic         clr_ovf;
  logic [W-1:0] q;
  logic         rco;
  logic         ovf;
  logic         valid;

  modport master (output enb, a, b, cin, modo, clr_ovf,
                  input  q, rco, ovf, valid);
  modport slave  (input  enb, a, b, cin, modo, clr_ovf,
                  output q, rco, ovf, valid);
endinterface

// File: rtl/sumador_alu.sv
// rtl/sumador_alu.sv - combinational next-Q/next-RCO for load, add, subtract, accumulate
module sumador_alu
  import sumador_pkg::*;
#(
  parameter int W   = 8,
  parameter bit SAT = 1'b0
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] q,
  input  logic         cin,
  input  logic [1:0]   modo,
  output logic [W-1:0] q_next,
  output logic         rco_next
);

  logic [W-1:0]   lhs, rhs;
  logic [MAX_W:0] res;
  logic           unused_res_hi;

  // ACC folds the registered Q in as the left operand and A as the right.
  assign lhs = (modo == MODO_ACC) ? q : a;
  assign rhs = (modo == MODO_ACC) ? a : b;
  assign res = addsub({{(MAX_W-W){1'b0}}, lhs}, {{(MAX_W-W){1'b0}}, rhs},
                      cin, modo == MODO_SUB);
  assign unused_res_hi = ^res[MAX_W:W+1];

  always_comb begin
    q_next   = res[W-1:0];
    rco_next = res[W];
    case (modo)
      MODO_LOAD: begin
        q_next   = a;
        rco_next = 1'b0;
      end
      MODO_SUB: begin
        if (SAT && res[W]) q_next = '0;
      end
      default: begin
        if (SAT && res[W]) q_next = '1;
      end
    endcase
  end

endmodule

// File: rtl/sumador_param.sv
// rtl/sumador_param.sv - registered W-bit add/sub/accumulate unit with sticky overflow
module sumador_param
  import sumador_pkg::*;
#(
  parameter int W   = 8,
  parameter bit SAT = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  sumador_param_if.slave  bus
);

  logic [W-1:0] q_r, q_next;
  logic         rco_r, rco_next;
  logic         ovf_r, valid_r;

  sumador_alu #(.W(W), .SAT(SAT)) u_alu (
    .a        (bus.a),
    .b        (bus.b),
    .q        (q_r),
    .cin      (bus.cin),
    .modo     (bus.modo),
    .q_next   (q_next),
    .rco_next (rco_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      q_r     <= '0;
      rco_r   <= 1'b0;
      ovf_r   <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      valid_r <= bus.enb;
      if (bus.enb) begin
        q_r   <= q_next;
        rco_r <= rco_next;
      end
      // A new overflow outranks a clear arriving in the same cycle.
      if (bus.enb && rco_next) ovf_r <= 1'b1;
      else if (bus.clr_ovf)    ovf_r <= 1'b0;
    end
  end

  assign bus.q     = q_r;
  assign bus.rco   = rco_r;
  assign bus.ovf   = ovf_r;
  assign bus.valid = valid_r;

endmodule
